// File: rtl/freq_test_gen.sv
// freq_test_gen: multi-channel square-wave generator with run-time half-period registers.
// Define FTG_COMPLEMENT_EN to add an inverted registered copy of every channel on Fout_o.
module freq_test_gen #(
  parameter int CHANNELS  = 12,
  parameter int DIV_W     = 16,
  parameter int ADDR_W    = 5,
  parameter int HALF_INIT = 1,
`ifdef FTG_COMPLEMENT_EN
  localparam int OUT_W = 2 * CHANNELS
`else
  localparam int OUT_W = CHANNELS
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DIV_W-1:0]    wr_data_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] rise_o,
  output logic [OUT_W-1:0]    Fout_o
);
  logic [DIV_W-1:0]    half [CHANNELS];
  logic [DIV_W-1:0]    cnt  [CHANNELS];
  logic [CHANNELS-1:0] out;
`ifdef FTG_COMPLEMENT_EN
  logic [CHANNELS-1:0] comp;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out    <= '0;
      rise_o <= '0;
`ifdef FTG_COMPLEMENT_EN
      comp   <= '1;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        half[i] <= DIV_W'(HALF_INIT + i);
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // compare below still sees the old half; a write lands for the next edge
        if (wr_en_i && wr_addr_i == ADDR_W'(i)) half[i] <= wr_data_i;
        if (sync_i || !en_i[i]) begin
          cnt[i]    <= '0;
          out[i]    <= 1'b0;
          rise_o[i] <= 1'b0;
`ifdef FTG_COMPLEMENT_EN
          comp[i]   <= 1'b1;
`endif
        end else if (cnt[i] >= half[i]) begin
          cnt[i]    <= '0;
          out[i]    <= ~out[i];
          rise_o[i] <= ~out[i];
`ifdef FTG_COMPLEMENT_EN
          comp[i]   <= out[i];
`endif
        end else begin
          cnt[i]    <= cnt[i] + DIV_W'(1);
          rise_o[i] <= 1'b0;
        end
      end
    end
  end
`ifdef FTG_COMPLEMENT_EN
  assign Fout_o = {comp, out};
`else
  assign Fout_o = out;
`endif
endmodule
